// File: rtl/vdc_ram_engine.sv
// VDC RAM engine: CPU-visible update/block address registers (R18/R19,
// R32/R33), word count (R30) and data (R31), plus the sequencer that turns
// those register accesses into single-byte RAM reads/writes, prefetches,
// block fills and block copies over a registered req/ack RAM port.
module vdc_ram_engine #(
  parameter int ADDR_W = 16,
  parameter int MAX_WC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rs,
  input  logic              we,
  input  logic [7:0]        db_in,
  output logic [7:0]        db_out,
  output logic [7:0]        reg_sel,
  output logic              hit,
  output logic              busy,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ack,
  input  logic              copy_mode
);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    WRITE1,
    FILL,
    CP_RD,
    CP_WR
  } state_e;

  localparam logic [7:0] R_UA_HI = 8'd18;
  localparam logic [7:0] R_UA_LO = 8'd19;
  localparam logic [7:0] R_WC    = 8'd30;
  localparam logic [7:0] R_DA    = 8'd31;
  localparam logic [7:0] R_BA_HI = 8'd32;
  localparam logic [7:0] R_BA_LO = 8'd33;

  state_e              state_q;
  logic [15:0]         ua_q;
  logic [15:0]         ba_q;
  logic [7:0]          wc_q;
  logic [7:0]          da_q;
  logic [8:0]          ops_q;      // remaining block ops; wc alone cannot hold 256
  logic [7:0]          reg_sel_q;
  logic [7:0]          db_out_q;
  logic                ram_req_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_wdata_q;

  logic [15:0]         ua_inc_d;
  logic [15:0]         ba_inc_d;
  logic [8:0]          ops_load_d;
  logic                last_op;

  assign ua_inc_d   = ua_q + 16'd1;
  assign ba_inc_d   = ba_q + 16'd1;
  // An R30 value of 0 means the full MAX_WC-op block.
  assign ops_load_d = (db_in == 8'd0) ? 9'(MAX_WC) : {1'b0, db_in};
  assign last_op    = (ops_q == 9'd1);

  assign busy      = (state_q != IDLE);
  assign hit       = ~rs | (reg_sel_q == R_UA_HI) | (reg_sel_q == R_UA_LO) |
                     ((reg_sel_q >= R_WC) && (reg_sel_q <= R_BA_LO));
  assign db_out    = db_out_q;
  assign reg_sel   = reg_sel_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Sequencer: accepts data-port commands in IDLE and runs RAM transfers.
  // Each transfer is issued one edge after entering/looping a state and
  // retired on ack, so a new request never overlaps the previous ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ua_q        <= '0;
      ba_q        <= '0;
      wc_q        <= '0;
      da_q        <= '0;
      ops_q       <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      // NOTE: every register here is assigned with <= so all decisions use
      // pre-edge values; a CPU access therefore sees the state before the edge.
      case (state_q)
        IDLE: begin
          if (cs && rs && we) begin
            case (reg_sel_q)
              R_UA_HI: begin ua_q[15:8] <= db_in; state_q <= PREFETCH; end
              R_UA_LO: begin ua_q[7:0]  <= db_in; state_q <= PREFETCH; end
              R_WC: begin
                wc_q    <= db_in;
                ops_q   <= ops_load_d;
                state_q <= copy_mode ? CP_RD : FILL;
              end
              R_DA:    begin da_q <= db_in; state_q <= WRITE1; end
              R_BA_HI: ba_q[15:8] <= db_in;
              R_BA_LO: ba_q[7:0]  <= db_in;
              default: ;
            endcase
          end else if (cs && rs && !we && (reg_sel_q == R_DA)) begin
            ua_q    <= ua_inc_d;
            state_q <= PREFETCH;
          end
        end

        PREFETCH: begin
          if (!ram_req_q) begin
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= ua_q[ADDR_W-1:0];
          end else if (ram_ack) begin
            ram_req_q <= 1'b0;
            da_q      <= ram_rdata;
            state_q   <= IDLE;
          end
        end

        WRITE1: begin
          if (!ram_req_q) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= ua_q[ADDR_W-1:0];
            ram_wdata_q <= da_q;
          end else if (ram_ack) begin
            ram_req_q <= 1'b0;
            ua_q      <= ua_inc_d;
            state_q   <= PREFETCH;
          end
        end

        FILL, CP_WR: begin
          if (!ram_req_q) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= ua_q[ADDR_W-1:0];
            ram_wdata_q <= da_q;
          end else if (ram_ack) begin
            ram_req_q <= 1'b0;
            ua_q      <= ua_inc_d;
            ops_q     <= ops_q - 9'd1;
            if (last_op) begin
              // Forced to 0 so a short MAX_WC block also ends with wc reading 0.
              wc_q    <= 8'd0;
              state_q <= IDLE;
            end else begin
              wc_q    <= wc_q - 8'd1;
              state_q <= (state_q == CP_WR) ? CP_RD : FILL;
            end
          end
        end

        CP_RD: begin
          if (!ram_req_q) begin
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= ba_q[ADDR_W-1:0];
          end else if (ram_ack) begin
            ram_req_q <= 1'b0;
            da_q      <= ram_rdata;
            ba_q      <= ba_inc_d;
            state_q   <= CP_WR;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // CPU side: register select writes and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_sel_q <= '0;
      db_out_q  <= '0;
    end else begin
      if (cs && !rs && we) begin
        reg_sel_q <= db_in;
      end
      if (cs && !we) begin
        if (!rs) begin
          db_out_q <= {~busy, 7'b0000000};
        end else begin
          case (reg_sel_q)
            R_UA_HI: db_out_q <= ua_q[15:8];
            R_UA_LO: db_out_q <= ua_q[7:0];
            R_WC:    db_out_q <= wc_q;
            R_DA:    db_out_q <= da_q;
            R_BA_HI: db_out_q <= ba_q[15:8];
            R_BA_LO: db_out_q <= ba_q[7:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vdc_ram_engine.sv
// Directed bench for vdc_ram_engine: a 64k instance and a 16k (ADDR_W=14)
// instance share the CPU bus; each has its own RAM model with a programmable
// ack delay.
module tb_vdc_ram_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, rs, we, copy_mode;
  logic [7:0]  db_in;

  logic [7:0]  db_out, reg_sel, ram_wdata, ram_rdata;
  logic        hit, busy, ram_req, ram_we, ram_ack;
  logic [15:0] ram_addr;

  logic [7:0]  db_out14, reg_sel14, ram_wdata14, ram_rdata14;
  logic        hit14, busy14, ram_req14, ram_we14, ram_ack14;
  logic [13:0] ram_addr14;

  int vectors = 0;
  int miscompares = 0;
  int ack_dly = 0;
  int wr_acks = 0;

  logic [7:0]  mem16 [0:65535];
  logic [7:0]  mem14 [0:16383];
  logic [13:0] last_wr14, last_rd14;
  logic [7:0]  d, d14;

  always #5 clk = ~clk;

  vdc_ram_engine #(.ADDR_W(16), .MAX_WC(256)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rs(rs), .we(we), .db_in(db_in),
    .db_out(db_out), .reg_sel(reg_sel), .hit(hit), .busy(busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .copy_mode(copy_mode)
  );

  vdc_ram_engine #(.ADDR_W(14), .MAX_WC(256)) dut14 (
    .clk(clk), .reset(reset), .cs(cs), .rs(rs), .we(we), .db_in(db_in),
    .db_out(db_out14), .reg_sel(reg_sel14), .hit(hit14), .busy(busy14),
    .ram_req(ram_req14), .ram_we(ram_we14), .ram_addr(ram_addr14),
    .ram_wdata(ram_wdata14), .ram_rdata(ram_rdata14), .ram_ack(ram_ack14),
    .copy_mode(copy_mode)
  );

  // 64k RAM model; also checks the request stays stable while waiting for ack.
  int          w16 = 0;
  logic [24:0] hold16;
  always @(negedge clk) begin
    if (ram_req && !ram_ack) begin
      if (w16 == 0) begin
        hold16 = {ram_addr, ram_we, ram_wdata};
      end else begin
        vectors++;
        if ({ram_addr, ram_we, ram_wdata} !== hold16) begin
          miscompares++;
          $display("FAIL req_stable: got %h required %h", {ram_addr, ram_we, ram_wdata}, hold16);
        end
      end
      if (w16 >= ack_dly) begin
        ram_ack   = 1'b1;
        ram_rdata = mem16[ram_addr];
        if (ram_we) begin
          mem16[ram_addr] = ram_wdata;
          wr_acks++;
        end
        w16 = 0;
      end else begin
        w16++;
      end
    end else begin
      ram_ack = 1'b0;
      w16 = 0;
    end
  end

  // 16k RAM model; records the last read and write addresses.
  int w14 = 0;
  always @(negedge clk) begin
    if (ram_req14 && !ram_ack14) begin
      if (w14 >= ack_dly) begin
        ram_ack14   = 1'b1;
        ram_rdata14 = mem14[ram_addr14];
        if (ram_we14) begin
          mem14[ram_addr14] = ram_wdata14;
          last_wr14 = ram_addr14;
        end else begin
          last_rd14 = ram_addr14;
        end
        w14 = 0;
      end else begin
        w14++;
      end
    end else begin
      ram_ack14 = 1'b0;
      w14 = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic r, input logic [7:0] v);
    cs = 1'b1; rs = r; we = 1'b1; db_in = v;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic r, output logic [7:0] v, output logic [7:0] v14);
    cs = 1'b1; rs = r; we = 1'b0;
    tick();
    cs = 1'b0;
    v = db_out;
    v14 = db_out14;
  endtask

  task automatic set_reg(input logic [7:0] idx, input logic [7:0] v);
    cpu_wr(1'b0, idx);
    cpu_wr(1'b1, v);
  endtask

  task automatic get_reg(input logic [7:0] idx, output logic [7:0] v, output logic [7:0] v14);
    cpu_wr(1'b0, idx);
    cpu_rd(1'b1, v, v14);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || busy14) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy || busy14) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b busy14=%b after %0d cycles, required 0", busy, busy14, budget);
    end
  endtask

  task automatic set_ua(input logic [15:0] a);
    set_reg(8'd18, a[15:8]);
    wait_idle(100);
    set_reg(8'd19, a[7:0]);
    wait_idle(100);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({db_out, reg_sel, busy, ram_req, ram_we, ram_addr, ram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", {db_out, reg_sel, busy, ram_req, ram_we, ram_addr, ram_wdata});
    end
    rs = 1'b0; #1;
    vectors++;
    if (hit !== 1'b1) begin miscompares++; $display("FAIL hit_rs0: got %b required 1", hit); end
    rs = 1'b1; #1;
    vectors++;
    if (hit !== 1'b0) begin miscompares++; $display("FAIL hit_sel0: got %b required 0", hit); end
    cpu_wr(1'b0, 8'd34); rs = 1'b1; #1;
    vectors++;
    if (hit !== 1'b0) begin miscompares++; $display("FAIL hit_sel34: got %b required 0", hit); end
    cpu_wr(1'b0, 8'd33); rs = 1'b1; #1;
    vectors++;
    if (hit !== 1'b1) begin miscompares++; $display("FAIL hit_sel33: got %b required 1", hit); end
    cpu_rd(1'b0, d, d14);
    vectors++;
    if (d !== 8'h80) begin miscompares++; $display("FAIL status_idle: got %h required 80", d); end
    get_reg(8'd18, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_ua_hi: got %h required 00", d); end
    get_reg(8'd30, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_wc: got %h required 00", d); end
  endtask

  task automatic test_single_write();
    ack_dly = 2;
    set_ua(16'h1000);
    wr_acks = 0;
    set_reg(8'd31, 8'hA5);
    vectors++;
    if (hit !== 1'b1) begin miscompares++; $display("FAIL hit_sel31: got %b required 1", hit); end
    wait_idle(100);
    vectors++;
    if (mem16[16'h1000] !== 8'hA5) begin miscompares++; $display("FAIL write1_ram: got %h required a5", mem16[16'h1000]); end
    vectors++;
    if (wr_acks !== 1) begin miscompares++; $display("FAIL write1_acks: got %0d required 1", wr_acks); end
    get_reg(8'd18, d, d14);
    vectors++;
    if (d !== 8'h10) begin miscompares++; $display("FAIL write1_ua_hi: got %h required 10", d); end
    get_reg(8'd19, d, d14);
    vectors++;
    if (d !== 8'h01) begin miscompares++; $display("FAIL write1_ua_lo: got %h required 01", d); end
    get_reg(8'd31, d, d14);
    vectors++;
    if (d !== 8'h5C) begin miscompares++; $display("FAIL write1_prefetch_da: got %h required 5c", d); end
    wait_idle(100);
    get_reg(8'd19, d, d14);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL r31_read_inc: got %h required 02", d); end
  endtask

  task automatic test_fill();
    ack_dly = 1;
    set_ua(16'h0FFD);
    set_reg(8'd31, 8'h20);
    wait_idle(100);
    wr_acks = 0;
    copy_mode = 1'b0;
    set_reg(8'd30, 8'd4);
    wait_idle(200);
    vectors++;
    if ({mem16[16'h0FFD], mem16[16'h0FFE], mem16[16'h0FFF], mem16[16'h1000], mem16[16'h1001]} !== {5{8'h20}}) begin
      miscompares++;
      $display("FAIL fill_ram: got %h required 2020202020",
               {mem16[16'h0FFD], mem16[16'h0FFE], mem16[16'h0FFF], mem16[16'h1000], mem16[16'h1001]});
    end
    vectors++;
    if (mem16[16'h1002] !== 8'h77) begin miscompares++; $display("FAIL fill_overrun: got %h required 77", mem16[16'h1002]); end
    vectors++;
    if (wr_acks !== 4) begin miscompares++; $display("FAIL fill_acks: got %0d required 4", wr_acks); end
    get_reg(8'd19, d, d14);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL fill_ua_lo: got %h required 02", d); end
    get_reg(8'd30, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL fill_wc: got %h required 00", d); end
    get_reg(8'd31, d, d14);
    vectors++;
    if (d !== 8'h20) begin miscompares++; $display("FAIL fill_da: got %h required 20", d); end
    wait_idle(100);
  endtask

  task automatic test_copy_wrap();
    ack_dly = 2;
    set_reg(8'd32, 8'hFF);
    set_reg(8'd33, 8'hFF);
    set_ua(16'h2000);
    wr_acks = 0;
    copy_mode = 1'b1;
    set_reg(8'd30, 8'd2);
    copy_mode = 1'b0;
    wait_idle(200);
    vectors++;
    if ({mem16[16'h2000], mem16[16'h2001]} !== 16'hC33C) begin
      miscompares++;
      $display("FAIL copy_ram: got %h required c33c", {mem16[16'h2000], mem16[16'h2001]});
    end
    vectors++;
    if (wr_acks !== 2) begin miscompares++; $display("FAIL copy_acks: got %0d required 2", wr_acks); end
    get_reg(8'd32, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL copy_ba_hi: got %h required 00", d); end
    get_reg(8'd33, d, d14);
    vectors++;
    if (d !== 8'h01) begin miscompares++; $display("FAIL copy_ba_lo: got %h required 01", d); end
    get_reg(8'd19, d, d14);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL copy_ua_lo: got %h required 02", d); end
    get_reg(8'd31, d, d14);
    vectors++;
    if (d !== 8'h3C) begin miscompares++; $display("FAIL copy_da: got %h required 3c", d); end
    wait_idle(100);
  endtask

  task automatic test_big_fill();
    ack_dly = 0;
    set_ua(16'h4000);
    wr_acks = 0;
    copy_mode = 1'b0;
    set_reg(8'd30, 8'd0);
    repeat (20) tick();
    cpu_rd(1'b0, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL status_busy: got %h required 00", d); end
    set_reg(8'd31, 8'hEE);
    wait_idle(2000);
    vectors++;
    if (wr_acks !== 256) begin miscompares++; $display("FAIL bigfill_acks: got %0d required 256", wr_acks); end
    cpu_rd(1'b0, d, d14);
    vectors++;
    if (d !== 8'h80) begin miscompares++; $display("FAIL status_done: got %h required 80", d); end
    vectors++;
    if ({mem16[16'h40FF], mem16[16'h4100]} !== 16'h5A99) begin
      miscompares++;
      $display("FAIL bigfill_edges: got %h required 5a99", {mem16[16'h40FF], mem16[16'h4100]});
    end
    get_reg(8'd18, d, d14);
    vectors++;
    if (d !== 8'h41) begin miscompares++; $display("FAIL bigfill_ua_hi: got %h required 41", d); end
    get_reg(8'd30, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL bigfill_wc: got %h required 00", d); end
    get_reg(8'd31, d, d14);
    vectors++;
    if (d !== 8'h5A) begin miscompares++; $display("FAIL bigfill_da_ignored_wr: got %h required 5a", d); end
    wait_idle(100);
  endtask

  task automatic test_addr14();
    ack_dly = 1;
    set_ua(16'h3FFF);
    set_reg(8'd31, 8'h66);
    wait_idle(100);
    vectors++;
    if (last_wr14 !== 14'h3FFF) begin miscompares++; $display("FAIL a14_wr_addr: got %h required 3fff", last_wr14); end
    vectors++;
    if (last_rd14 !== 14'h0000) begin miscompares++; $display("FAIL a14_prefetch_addr: got %h required 0000", last_rd14); end
    vectors++;
    if (mem14[14'h3FFF] !== 8'h66) begin miscompares++; $display("FAIL a14_ram: got %h required 66", mem14[14'h3FFF]); end
    get_reg(8'd18, d, d14);
    vectors++;
    if (d14 !== 8'h40) begin miscompares++; $display("FAIL a14_ua_hi: got %h required 40", d14); end
    vectors++;
    if (d !== 8'h40) begin miscompares++; $display("FAIL a16_ua_hi: got %h required 40", d); end
    get_reg(8'd19, d, d14);
    vectors++;
    if (d14 !== 8'h00) begin miscompares++; $display("FAIL a14_ua_lo: got %h required 00", d14); end
  endtask

  task automatic test_reset_mid_copy();
    int n = 0;
    ack_dly = 5;
    set_reg(8'd32, 8'h12);
    set_reg(8'd33, 8'h34);
    set_ua(16'h5678);
    wr_acks = 0;
    copy_mode = 1'b1;
    set_reg(8'd30, 8'd3);
    while (!ram_req && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (ram_req !== 1'b1) begin miscompares++; $display("FAIL midcopy_req: got %b required 1", ram_req); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({ram_req, busy, ram_we, ram_addr, ram_wdata, db_out, reg_sel} !== '0) begin
      miscompares++;
      $display("FAIL midcopy_reset_outputs: got %h required 0", {ram_req, busy, ram_we, ram_addr, ram_wdata, db_out, reg_sel});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    copy_mode = 1'b0;
    repeat (10) tick();
    vectors++;
    if (wr_acks !== 0) begin miscompares++; $display("FAIL midcopy_no_writes: got %0d required 0", wr_acks); end
    get_reg(8'd33, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL midcopy_ba_lo: got %h required 00", d); end
    get_reg(8'd19, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL midcopy_ua_lo: got %h required 00", d); end
    get_reg(8'd30, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL midcopy_wc: got %h required 00", d); end
    get_reg(8'd31, d, d14);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL midcopy_da: got %h required 00", d); end
    wait_idle(100);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rs = 1'b0; we = 1'b0; db_in = 8'h00; copy_mode = 1'b0;
    ram_ack = 1'b0; ram_rdata = 8'h00; ram_ack14 = 1'b0; ram_rdata14 = 8'h00;
    last_wr14 = '0; last_rd14 = '0;
    for (int i = 0; i < 65536; i++) mem16[i] = 8'h00;
    for (int i = 0; i < 16384; i++) mem14[i] = 8'h00;
    mem16[16'h1001] = 8'h5C;
    mem16[16'h0FFE] = 8'h20;
    mem16[16'h0FFF] = 8'h11;
    mem16[16'h1002] = 8'h77;
    mem16[16'hFFFF] = 8'hC3;
    mem16[16'h0000] = 8'h3C;
    mem16[16'h4000] = 8'h5A;
    mem16[16'h4100] = 8'h99;

    test_reset();
    test_single_write();
    test_fill();
    test_copy_wrap();
    test_big_fill();
    test_addr14();
    test_reset_mid_copy();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
